// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bundle for dmem_arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          done_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          done_b;
  logic [DW-1:0] rdata_b;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output gnt_a, done_a, rdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_b, done_b, rdata_b,
    output mem_addr, mem_we, mem_re, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  gnt_a, done_a, rdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_b, done_b, rdata_b,
    input  mem_addr, mem_we, mem_re, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory; fixed 3-cycle transactions.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           r_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic          done_a_q, done_a_d;
  logic          done_b_q, done_b_d;
  logic          owner_b_q, owner_b_d;
  logic          rd_q, rd_d;
  logic          last_b_q, last_b_d;

  logic          tie_a;
  logic          grant_a, grant_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  assign tie_a = last_b_q;
`else
  assign tie_a = 1'b1;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req_a && (!bus.req_b || tie_a)) grant_a = 1'b1;
      else if (bus.req_b)                     grant_b = 1'b1;
    end
  end

  always_comb begin
    sel_we    = bus.we_a;
    sel_addr  = bus.addr_a;
    sel_wdata = bus.wdata_a;
    if (grant_b) begin
      sel_we    = bus.we_b;
      sel_addr  = bus.addr_b;
      sel_wdata = bus.wdata_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    owner_b_d   = owner_b_q;
    rd_d        = rd_q;
    last_b_d    = last_b_q;
    unique case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_we;
          mem_re_d    = !sel_we;
          owner_b_d   = grant_b;
          rd_d        = !sel_we;
          last_b_d    = grant_b;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Strobes last one cycle; address/data hold so the memory sees a stable bus.
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        done_a_d = !owner_b_q;
        done_b_d = owner_b_q;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      owner_b_q   <= 1'b0;
      rd_q        <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      owner_b_q   <= owner_b_d;
      rd_q        <= rd_d;
      last_b_q    <= last_b_d;
    end
  end

  assign bus.gnt_a     = grant_a;
  assign bus.gnt_b     = grant_b;
  assign bus.done_a    = done_a_q;
  assign bus.done_b    = done_b_q;
  assign bus.rdata_a   = (done_a_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.rdata_b   = (done_b_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a transaction-level model with its own memory.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit FIXED_PRIO = 1'b0;
`else
  localparam bit FIXED_PRIO = 1'b1;
`endif

  logic clk = 1'b0;
  logic r_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .r_n (r_n),
    .bus (bus)
  );

  // Stand-in for data_memory: registered read, write at the edge.
  bit [DW-1:0] smem [1024];
  always @(posedge clk) begin
    if (bus.mem_we) smem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= smem[bus.mem_addr];
  end

  // Reference memory for the randomized phase.
  bit [DW-1:0] mmem [1024];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    string       name;
    bit          port_b;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit pb, input bit rq, input bit we, input logic [9:0] addr,
                       input logic [31:0] wdata);
    if (pb) begin
      bus.req_b = rq; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
    end else begin
      bus.req_a = rq; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
    end
  endtask

  task automatic reset_dut();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    r_n = 1'b0;
    #3;
    chk("rst_mem_we",    bus.mem_we,    0);
    chk("rst_mem_re",    bus.mem_re,    0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_done",      {bus.done_a, bus.done_b}, 0);
    chk("rst_rdata_a",   bus.rdata_a,   0);
    chk("rst_rdata_b",   bus.rdata_b,   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    r_n = 1'b1;
    @(negedge clk);
    chk("rst_after_release", {bus.mem_we, bus.mem_re, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b}, 0);
  endtask

  task automatic do_txn(input vec_t v);
    bit got;
    @(posedge clk); #1;
    drive(v.port_b, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    got = v.port_b ? bus.gnt_b : bus.gnt_a;
    chk({v.name, "_gnt"}, got, 1);
    chk({v.name, "_gnt_other"}, v.port_b ? bus.gnt_a : bus.gnt_b, 0);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = v.port_b ? bus.gnt_b : bus.gnt_a;
    end
    @(posedge clk); #1;
    drive(v.port_b, 1'b0, v.we, v.addr, v.wdata);
    if (!got) return;
    @(negedge clk);
    chk({v.name, "_issue_we"},   bus.mem_we,   v.we);
    chk({v.name, "_issue_re"},   bus.mem_re,   !v.we);
    chk({v.name, "_issue_addr"}, bus.mem_addr, v.addr);
    if (v.we) chk({v.name, "_issue_wdata"}, bus.mem_wdata, v.wdata);
    chk({v.name, "_issue_done"}, {bus.done_a, bus.done_b}, 0);
    @(negedge clk);
    chk({v.name, "_done"},       v.port_b ? bus.done_b : bus.done_a, 1);
    chk({v.name, "_done_other"}, v.port_b ? bus.done_a : bus.done_b, 0);
    chk({v.name, "_rdata"},      v.port_b ? bus.rdata_b : bus.rdata_a, v.we ? 32'h0 : v.exp_rd);
    chk({v.name, "_rdata_other"}, v.port_b ? bus.rdata_a : bus.rdata_b, 0);
    chk({v.name, "_resp_strobes"}, {bus.mem_we, bus.mem_re}, 0);
  endtask

  task automatic random_phase(input int unsigned ncyc);
    int          phase = 0;
    bit          own_b = 1'b0, m_we = 1'b0, last_b = 1'b1, ga, gb, tie_a;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rd = '0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ga = 1'b0; gb = 1'b0;
      tie_a = last_b | FIXED_PRIO;
      if (phase == 0) begin
        if (bus.req_a && (!bus.req_b || tie_a)) ga = 1'b1;
        else if (bus.req_b)                     gb = 1'b1;
      end
      chk("rnd_gnt_a",   bus.gnt_a,  ga);
      chk("rnd_gnt_b",   bus.gnt_b,  gb);
      chk("rnd_done_a",  bus.done_a, phase == 2 && !own_b);
      chk("rnd_done_b",  bus.done_b, phase == 2 && own_b);
      chk("rnd_rdata_a", bus.rdata_a, (phase == 2 && !own_b) ? m_rd : 32'h0);
      chk("rnd_rdata_b", bus.rdata_b, (phase == 2 && own_b)  ? m_rd : 32'h0);
      chk("rnd_mem_we",  bus.mem_we, phase == 1 && m_we);
      chk("rnd_mem_re",  bus.mem_re, phase == 1 && !m_we);
      if (phase == 1) begin
        chk("rnd_mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
      end
      // Transaction-level model: a grant commits the whole access atomically.
      case (phase)
        0: if (ga || gb) begin
             own_b   = gb;
             m_we    = gb ? bus.we_b    : bus.we_a;
             m_addr  = gb ? bus.addr_b  : bus.addr_a;
             m_wdata = gb ? bus.wdata_b : bus.wdata_a;
             m_rd    = m_we ? 32'h0 : mmem[m_addr];
             if (m_we) mmem[m_addr] = m_wdata;
             last_b  = gb;
             phase   = 1;
           end
        1: phase = 2;
        default: phase = 0;
      endcase
      @(posedge clk); #1;
      if (ga) bus.req_a = 1'b0;
      if (gb) bus.req_b = 1'b0;
      if (!bus.req_a && $urandom_range(0, 2) != 0)
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 10'(16 + $urandom_range(0, 7)), $urandom);
      if (!bus.req_b && $urandom_range(0, 2) != 0)
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 10'(16 + $urandom_range(0, 7)), $urandom);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int unsigned order [4];
    int unsigned n;

    vecs[0] = '{"wrA5",   1'b0, 1'b1, 10'd5,   32'h1234ABCD, 32'h0};
    vecs[1] = '{"rdA5",   1'b0, 1'b0, 10'd5,   32'h0,        32'h1234ABCD};
    vecs[2] = '{"wrB9",   1'b1, 1'b1, 10'd9,   32'hDEADBEEF, 32'h0};
    vecs[3] = '{"rdA9",   1'b0, 1'b0, 10'd9,   32'h0,        32'hDEADBEEF};
    vecs[4] = '{"rdB5",   1'b1, 1'b0, 10'd5,   32'h0,        32'h1234ABCD};
    vecs[5] = '{"wrA3ff", 1'b0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{"rdB3ff", 1'b1, 1'b0, 10'h3FF, 32'h0,        32'hFFFFFFFF};
    vecs[7] = '{"wrB0",   1'b1, 1'b1, 10'd0,   32'hA5A5_5A5A, 32'h0};
    vecs[8] = '{"wrA0",   1'b0, 1'b1, 10'd0,   32'h0000_0001, 32'h0};
    vecs[9] = '{"rdB0",   1'b1, 1'b0, 10'd0,   32'h0,        32'h0000_0001};

    reset_dut();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {bus.mem_we, bus.mem_re, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b}, 0);
    end

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Continuous tie on reads straight out of reset.
    reset_dut();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'd1, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 10'd2, 32'h0);
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      chk("tie_exclusive", bus.gnt_a & bus.gnt_b, 0);
      if (bus.gnt_a)      begin order[n] = 0; n++; end
      else if (bus.gnt_b) begin order[n] = 1; n++; end
    end
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    chk("tie_count", n, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i), order[i], FIXED_PRIO ? 0 : (i % 2));
    repeat (3) @(negedge clk);

    // Request raised during ISSUE waits for the next IDLE cycle.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'd5, 32'h0);
    @(negedge clk);
    chk("late_gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 10'd9, 32'h0);
    @(negedge clk);
    chk("late_gnt_b_issue", bus.gnt_b, 0);
    @(negedge clk);
    chk("late_gnt_b_resp", bus.gnt_b, 0);
    chk("late_done_a", bus.done_a, 1);
    @(negedge clk);
    chk("late_gnt_b_idle", bus.gnt_b, 1);
    @(posedge clk); #1;
    bus.req_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulled in ISSUE before the committing edge.
    reset_dut();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 10'd3, 32'h55);
    @(negedge clk);
    chk("rmw_gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    chk("rmw_we_armed", bus.mem_we, 1);
    #2 r_n = 1'b0;
    #1;
    chk("rmw_we_cleared", bus.mem_we, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rmw_no_done", {bus.done_a, bus.done_b, bus.mem_we}, 0);
    end
    r_n = 1'b1;
    @(negedge clk);
    chk("rmw_no_done_after", {bus.done_a, bus.done_b}, 0);
    do_txn('{"rdA3", 1'b0, 1'b0, 10'd3, 32'h0, 32'h0});

    // Reset during RESP drops done immediately.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'd5, 32'h0);
    @(negedge clk);
    chk("rresp_gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    @(posedge clk); #1;
    chk("rresp_done_before", bus.done_a, 1);
    chk("rresp_rdata_before", bus.rdata_a, 32'h1234ABCD);
    #2 r_n = 1'b0;
    #1;
    chk("rresp_done_dropped", bus.done_a, 0);
    chk("rresp_rdata_dropped", bus.rdata_a, 0);
    @(negedge clk);
    r_n = 1'b1;

    reset_dut();
    random_phase(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory` of the rv32i pipelined core. Port A is the pipeline MEM stage. Port B is the debug/DMA loader. The block accepts one request at a time, drives the memory's registered read/write interface, and returns read data or write completion to the requester that owns the transaction. Each transaction takes a fixed 3 cycles, so the MEM stage can stall on a deterministic handshake.

## Interface
Parameters:
- `AW`, 10, word address width; matches the data memory address port.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `r_n`  in  1  reset; asynchronous, active-low.
- `req_a` / `req_b`  in  1  request. Held high, with its command stable, until the matching `gnt_*` is seen.
- `we_a` / `we_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  AW  word address.
- `wdata_a` / `wdata_b`  in  DW  write data.
- `gnt_a` / `gnt_b`  out  1  combinational; high for the one cycle in which the request is accepted.
- `done_a` / `done_b`  out  1  registered one-cycle pulse; transaction complete.
- `rdata_a` / `rdata_b`  out  DW  read data; valid only while the matching `done_*` is high after a read, 0 otherwise.
- `mem_addr`  out  AW  registered; to memory `address`.
- `mem_we`  out  1  registered; to memory `write_en`.
- `mem_re`  out  1  registered; to memory `read_en`.
- `mem_wdata`  out  DW  registered; to memory `write_data`.
- `mem_rdata`  in  DW  from memory `read_data` (registered inside memory, 1-cycle latency).

## Operation
The block is a 3-state FSM: IDLE, ISSUE, RESP.

IDLE:
- If neither `req_*` is high, stay in IDLE.
- Otherwise choose a winner (rule below) and assert its `gnt_*` combinationally.
- At the edge, latch the winner's `we`, `addr` and `wdata` into `mem_*`:
  - `mem_we` = `we`.
  - `mem_re` = `!we`.
- Record the owner (A or B) and go to ISSUE.

ISSUE:
- `mem_*` are driven for exactly this cycle. The memory acts at the closing edge.
- At that edge, clear `mem_we` and `mem_re`. `mem_addr` and `mem_wdata` hold their values.
- Set the owner's `done_*` register and go to RESP.

RESP:
- The owner's `done_*` is high.
- If the transaction was a read, the owner's `rdata_*` = `mem_rdata`. Otherwise `rdata_*` = 0.
- The non-owner's outputs are 0.
- At the edge, clear `done_*` and return to IDLE.
- No request is accepted in RESP, so `gnt_*` is 0.

Arbitration:
- The winner is chosen only in IDLE.
- A single requester wins unconditionally.
- Both requesting: winner per Configuration.
- `gnt_a` and `gnt_b` are never high in the same cycle.
- `gnt_*` is 0 outside IDLE.

Pointer `last_b` (1 = B was the most recent grantee) updates at every grant edge.

## Timing
- Latency, grant edge to `done_*` high: 2 cycles. The request is accepted at cycle 0, `done_*` is high in cycle 2, and the next grant is possible in cycle 3.
- Maximum throughput: one transaction per 3 cycles.
- A request asserted during ISSUE or RESP waits and is granted in the next IDLE cycle.
- Write ordering: a write followed by a read to the same address (either port) returns the new data.
- Reset values, while `r_n` is low and after release:
  - state = IDLE;
  - `mem_we`, `mem_re` = 0;
  - `mem_addr`, `mem_wdata` = 0;
  - `done_a`, `done_b` = 0;
  - `rdata_a`, `rdata_b` = 0;
  - `last_b` = 1, so A wins the first tie.
- Reset during ISSUE: `mem_we` is forced to 0 asynchronously, so no write commits if reset is asserted before the edge. The transaction is dropped and no `done_*` is issued.
- Reset during RESP: `done_*` is dropped immediately.
- Requesters must re-request after reset.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on a tie. If `last_b` = 1, A wins; otherwise B wins. Neither port waits more than one transaction behind the other.
- Not defined: fixed priority on a tie; A always wins, and B can starve while A requests continuously. `last_b` is still maintained but unused.

## Test plan
- Single write then read, port A: write A addr 5, data 0x1234ABCD; then read A addr 5. Required: `gnt_a` in cycles 0 and 3, `done_a` in cycles 2 and 5, and `rdata_a` = 0x1234ABCD in cycle 5.
- Cross-port coherence: B writes addr 9 = 0xDEADBEEF, then A reads addr 9. Required: `rdata_a` = 0xDEADBEEF with `done_a`, and `rdata_b` stays 0 throughout.
- Tie arbitration: both ports request reads continuously for 4 transactions after reset.
  - With `DMEM_ARB_RR_EN`: grant order A, B, A, B.
  - Without: A, A, A, A, and `gnt_b` is never seen.
- Request timing: `req_b` rises in the cycle after `gnt_a` (ISSUE). Required: `gnt_b` is asserted exactly 2 cycles later (IDLE), never in ISSUE or RESP.
- Reset mid-write: A writes addr 3 = 0x55, and `r_n` is pulled low in the ISSUE cycle before the edge. Then, after release, A reads addr 3. Required:
  - `mem_we` = 0 immediately and no `done_a` is issued;
  - the read after release returns the prior value, 0 on a cleared memory.
- Idle stability: no requests for 10 cycles. Required: `mem_we`, `mem_re`, `gnt_*` and `done_*` are all 0, and the state stays IDLE.
